// File: rtl/rbt_pkg.sv
// Shared definitions for the reboot-loader RAM arbiter: FSM state encoding,
// CRC32 constants and the RAM-select encoding.
package rbt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_ACK  = 2'd2,
    ST_RBT  = 2'd3
  } rbt_state_e;

  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  localparam logic RAM_IRAM = 1'b0;
  localparam logic RAM_DRAM = 1'b1;

endpackage

// File: rtl/crc32_d32.sv
// Combinational CRC32 step over one 32-bit word (reflected form).
// Bytes are consumed LSB byte first, each byte LSB first, which in the
// reflected algorithm is simply data[0] .. data[31] in order.
// Ports:
//   crc_in  - accumulator before the word
//   data    - 32-bit word to fold in
//   crc_out - accumulator after the word
module crc32_d32
  import rbt_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int unsigned i = 0; i < 32; i++) begin
      c = c ^ {31'b0, data[i]};
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/rbt_ram_arb.sv
// Arbiter/sequencer granting the shared iram/dram either to the CPU data bus
// (Wishbone-classic, one access per IDLE->ACC->ACK pass) or to the I2C
// reboot loader (RBT). The CPU is held while the loader owns the RAMs, and a
// running CRC32 is kept over every accepted loader write.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   cpu_*                      - CPU bus request / response, cpu_hold to the CPU
//   rbt_*                      - loader session, RAM access, grant, sticky drop flag
//   crc_clr, crc32             - CRC accumulator clear and result
//   iram_*/dram_*              - single-port synchronous RAM interfaces
module rbt_ram_arb
  import rbt_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_stb,
  input  logic          cpu_we,
  input  logic [AW:0]   cpu_adr,
  input  logic [3:0]    cpu_sel,
  input  logic [31:0]   cpu_dat_wr,
  output logic [31:0]   cpu_dat_rd,
  output logic          cpu_ack,
  output logic          cpu_hold,
  input  logic          rbt_enable,
  input  logic          rbt_ram_sel,
  input  logic          rbt_ram_wr,
  input  logic [AW-1:0] rbt_ram_addr,
  input  logic [31:0]   rbt_ram_dat_wr,
  output logic [31:0]   rbt_ram_dat_rd,
  output logic          rbt_grant,
  output logic          rbt_wr_drop,
  input  logic          crc_clr,
  output logic [31:0]   crc32,
  output logic          iram_en,
  output logic          iram_we,
  output logic [3:0]    iram_be,
  output logic [AW-1:0] iram_addr,
  output logic [31:0]   iram_wdat,
  input  logic [31:0]   iram_rdat,
  output logic          dram_en,
  output logic          dram_we,
  output logic [3:0]    dram_be,
  output logic [AW-1:0] dram_addr,
  output logic [31:0]   dram_wdat,
  input  logic [31:0]   dram_rdat
);

  rbt_state_e    state_q, state_d;
  logic          cap_sel_q, cap_sel_d;
  logic          cap_we_q, cap_we_d;
  logic [3:0]    cap_be_q, cap_be_d;
  logic [AW-1:0] cap_addr_q, cap_addr_d;
  logic [31:0]   cap_wdat_q, cap_wdat_d;
  logic          rd_sel_q;
  logic          wr_drop_q, wr_drop_d;
  logic [31:0]   crc_q, crc_d;
  logic [31:0]   crc_step;
  logic          rbt_wr_ok;

  assign rbt_wr_ok = (state_q == ST_RBT) && rbt_ram_wr;

  crc32_d32 u_crc (
    .crc_in  (crc_q),
    .data    (rbt_ram_dat_wr),
    .crc_out (crc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cap_sel_q  <= RAM_IRAM;
      cap_we_q   <= 1'b0;
      cap_be_q   <= '0;
      cap_addr_q <= '0;
      cap_wdat_q <= '0;
      rd_sel_q   <= RAM_IRAM;
      wr_drop_q  <= 1'b0;
      crc_q      <= CRC32_INIT;
    end else begin
      state_q    <= state_d;
      cap_sel_q  <= cap_sel_d;
      cap_we_q   <= cap_we_d;
      cap_be_q   <= cap_be_d;
      cap_addr_q <= cap_addr_d;
      cap_wdat_q <= cap_wdat_d;
      rd_sel_q   <= rbt_ram_sel;
      wr_drop_q  <= wr_drop_d;
      crc_q      <= crc_d;
    end
  end

  // Next state, CPU capture, drop flag and CRC accumulator.
  always_comb begin
    state_d    = state_q;
    cap_sel_d  = cap_sel_q;
    cap_we_d   = cap_we_q;
    cap_be_d   = cap_be_q;
    cap_addr_d = cap_addr_q;
    cap_wdat_d = cap_wdat_q;
    wr_drop_d  = wr_drop_q | (rbt_ram_wr && (state_q != ST_RBT));
    crc_d      = crc_q;

    if (crc_clr) begin
      crc_d = CRC32_INIT;
    end else if (rbt_wr_ok) begin
      crc_d = crc_step;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rbt_enable) begin
          state_d = ST_RBT;
        end else if (cpu_stb) begin
          state_d    = ST_ACC;
          cap_sel_d  = cpu_adr[AW];
          cap_we_d   = cpu_we;
          cap_be_d   = cpu_sel;
          cap_addr_d = cpu_adr[AW-1:0];
          cap_wdat_d = cpu_dat_wr;
        end
      end
      ST_ACC:  state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      ST_RBT: begin
        if (!rbt_enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM ports and bus outputs.
  always_comb begin
    iram_en   = 1'b0;
    iram_we   = 1'b0;
    iram_be   = '0;
    iram_addr = '0;
    iram_wdat = '0;
    dram_en   = 1'b0;
    dram_we   = 1'b0;
    dram_be   = '0;
    dram_addr = '0;
    dram_wdat = '0;
    cpu_ack    = 1'b0;
    cpu_dat_rd = '0;
    rbt_grant  = 1'b0;

    unique case (state_q)
      ST_ACC: begin
        if (cap_sel_q == RAM_DRAM) begin
          dram_en   = 1'b1;
          dram_we   = cap_we_q;
          dram_be   = cap_be_q;
          dram_addr = cap_addr_q;
          dram_wdat = cap_wdat_q;
        end else begin
          iram_en   = 1'b1;
          iram_we   = cap_we_q;
          iram_be   = cap_be_q;
          iram_addr = cap_addr_q;
          iram_wdat = cap_wdat_q;
        end
      end
      ST_ACK: begin
        cpu_ack = 1'b1;
        if (!cap_we_q) begin
          cpu_dat_rd = (cap_sel_q == RAM_DRAM) ? dram_rdat : iram_rdat;
        end
      end
      ST_RBT: begin
        rbt_grant = 1'b1;
        if (rbt_ram_sel == RAM_DRAM) begin
          dram_en   = 1'b1;
          dram_we   = rbt_ram_wr;
          dram_be   = 4'hF;
          dram_addr = rbt_ram_addr;
          dram_wdat = rbt_ram_dat_wr;
        end else begin
          iram_en   = 1'b1;
          iram_we   = rbt_ram_wr;
          iram_be   = 4'hF;
          iram_addr = rbt_ram_addr;
          iram_wdat = rbt_ram_dat_wr;
        end
      end
      default: ;
    endcase
  end

  // Hold asserts as soon as the loader asks, even while a CPU access drains.
  assign cpu_hold       = (state_q == ST_RBT) || rbt_enable;
  assign rbt_ram_dat_rd = (rd_sel_q == RAM_DRAM) ? dram_rdat : iram_rdat;
  assign rbt_wr_drop    = wr_drop_q;
  assign crc32          = ~crc_q;

endmodule

// File: tb/tb_rbt_ram_arb.sv
module tb_rbt_ram_arb;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_stb, cpu_we;
  logic [AW:0]   cpu_adr;
  logic [3:0]    cpu_sel;
  logic [31:0]   cpu_dat_wr, cpu_dat_rd;
  logic          cpu_ack, cpu_hold;
  logic          rbt_enable, rbt_ram_sel, rbt_ram_wr;
  logic [AW-1:0] rbt_ram_addr;
  logic [31:0]   rbt_ram_dat_wr, rbt_ram_dat_rd;
  logic          rbt_grant, rbt_wr_drop, crc_clr;
  logic [31:0]   crc32;
  logic          iram_en, iram_we, dram_en, dram_we;
  logic [3:0]    iram_be, dram_be;
  logic [AW-1:0] iram_addr, dram_addr;
  logic [31:0]   iram_wdat, dram_wdat, iram_rdat, dram_rdat;

  int checks = 0;
  int failures = 0;

  // RAM models with a bench-only preload port.
  logic [31:0] iram_mem [0:255];
  logic [31:0] dram_mem [0:255];
  logic        bd_we, bd_dram;
  logic [7:0]  bd_addr;
  logic [31:0] bd_dat;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) begin
      if (bd_dram) dram_mem[bd_addr] <= bd_dat;
      else         iram_mem[bd_addr] <= bd_dat;
    end
    if (iram_en) begin
      iram_rdat <= iram_mem[iram_addr[7:0]];
      if (iram_we)
        for (int b = 0; b < 4; b++)
          if (iram_be[b]) iram_mem[iram_addr[7:0]][b*8 +: 8] <= iram_wdat[b*8 +: 8];
    end
    if (dram_en) begin
      dram_rdat <= dram_mem[dram_addr[7:0]];
      if (dram_we)
        for (int b = 0; b < 4; b++)
          if (dram_be[b]) dram_mem[dram_addr[7:0]][b*8 +: 8] <= dram_wdat[b*8 +: 8];
    end
  end

  rbt_ram_arb #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_sel(cpu_sel),
    .cpu_dat_wr(cpu_dat_wr), .cpu_dat_rd(cpu_dat_rd), .cpu_ack(cpu_ack),
    .cpu_hold(cpu_hold), .rbt_enable(rbt_enable), .rbt_ram_sel(rbt_ram_sel),
    .rbt_ram_wr(rbt_ram_wr), .rbt_ram_addr(rbt_ram_addr),
    .rbt_ram_dat_wr(rbt_ram_dat_wr), .rbt_ram_dat_rd(rbt_ram_dat_rd),
    .rbt_grant(rbt_grant), .rbt_wr_drop(rbt_wr_drop), .crc_clr(crc_clr),
    .crc32(crc32),
    .iram_en(iram_en), .iram_we(iram_we), .iram_be(iram_be),
    .iram_addr(iram_addr), .iram_wdat(iram_wdat), .iram_rdat(iram_rdat),
    .dram_en(dram_en), .dram_we(dram_we), .dram_be(dram_be),
    .dram_addr(dram_addr), .dram_wdat(dram_wdat), .dram_rdat(dram_rdat)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic dsel, input logic [7:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_dram = dsel; bd_addr = a; bd_dat = d;
    tick;
    bd_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_stb = 0; cpu_we = 0; cpu_adr = '0; cpu_sel = '0; cpu_dat_wr = '0;
    rbt_enable = 0; rbt_ram_sel = 0; rbt_ram_wr = 0; rbt_ram_addr = '0;
    rbt_ram_dat_wr = '0; crc_clr = 0;
    bd_we = 0; bd_dram = 0; bd_addr = '0; bd_dat = '0;

    preload(1'b0, 8'd0, 32'h5555_5555);
    preload(1'b0, 8'd3, 32'h1111_1111);
    preload(1'b0, 8'd8, 32'hDEAD_BEEF);
    preload(1'b1, 8'd4, 32'h0000_0000);

    // Reset values
    chk("rst_ack", {31'b0, cpu_ack}, 32'd0);
    chk("rst_dat_rd", cpu_dat_rd, 32'd0);
    chk("rst_hold", {31'b0, cpu_hold}, 32'd0);
    chk("rst_grant", {31'b0, rbt_grant}, 32'd0);
    chk("rst_drop", {31'b0, rbt_wr_drop}, 32'd0);
    chk("rst_crc", crc32, 32'd0);
    chk("rst_en", {30'b0, iram_en, dram_en}, 32'd0);
    rst_n = 1'b1;
    tick;

    // CPU write to dram[4], low two bytes
    cpu_stb = 1; cpu_we = 1; cpu_adr = 17'h1_0004; cpu_sel = 4'b0011;
    cpu_dat_wr = 32'hA5A5_1234;
    tick;
    chk("wr_acc_dram", {29'b0, dram_en, dram_we, iram_en}, 32'b110);
    chk("wr_acc_addr", {16'b0, dram_addr}, 32'd4);
    chk("wr_acc_be", {28'b0, dram_be}, 32'b0011);
    chk("wr_acc_wdat", dram_wdat, 32'hA5A5_1234);
    chk("wr_acc_noack", {31'b0, cpu_ack}, 32'd0);
    tick;
    chk("wr_ack", {31'b0, cpu_ack}, 32'd1);
    chk("wr_ack_dat", cpu_dat_rd, 32'd0);
    cpu_stb = 0;
    tick;
    chk("wr_ack_gone", {31'b0, cpu_ack}, 32'd0);
    chk("wr_mem", dram_mem[4], 32'h0000_1234);
    chk("wr_iram_untouched", iram_mem[8], 32'hDEAD_BEEF);

    // CPU read of iram[8]
    cpu_stb = 1; cpu_we = 0; cpu_adr = 17'h0_0008; cpu_sel = 4'hF;
    tick;
    chk("rd_acc_iram", {29'b0, iram_en, iram_we, dram_en}, 32'b100);
    tick;
    chk("rd_ack", {31'b0, cpu_ack}, 32'd1);
    chk("rd_dat", cpu_dat_rd, 32'hDEAD_BEEF);
    cpu_stb = 0;
    tick;

    // Handoff: loader asks while the CPU access is in ACC
    cpu_stb = 1; cpu_we = 0; cpu_adr = 17'h1_0004;
    tick;
    rbt_enable = 1;
    #1;
    chk("ho_hold_early", {31'b0, cpu_hold}, 32'd1);
    chk("ho_nogrant", {31'b0, rbt_grant}, 32'd0);
    tick;
    chk("ho_ack", {31'b0, cpu_ack}, 32'd1);
    chk("ho_dat", cpu_dat_rd, 32'h0000_1234);
    cpu_stb = 0;
    tick;
    chk("ho_ack_gone", {31'b0, cpu_ack}, 32'd0);
    tick;
    chk("ho_grant", {31'b0, rbt_grant}, 32'd1);
    chk("ho_hold", {31'b0, cpu_hold}, 32'd1);

    // Loader write 0 to iram[0] after a CRC clear
    crc_clr = 1;
    tick;
    crc_clr = 0;
    chk("crc_cleared", crc32, 32'd0);
    rbt_ram_sel = 0; rbt_ram_addr = 16'd0; rbt_ram_dat_wr = 32'd0; rbt_ram_wr = 1;
    #1;
    chk("ld_ctrl", {28'b0, iram_en, iram_we, dram_en, 1'b0}, 32'b1100);
    chk("ld_be", {28'b0, iram_be}, 32'hF);
    tick;
    rbt_ram_wr = 0;
    chk("ld_mem0", iram_mem[0], 32'd0);
    chk("ld_crc", crc32, 32'h2144_DF1C);
    tick;
    chk("ld_rd0", rbt_ram_dat_rd, 32'd0);
    rbt_ram_addr = 16'd8;
    tick;
    chk("ld_rd8", rbt_ram_dat_rd, 32'hDEAD_BEEF);
    rbt_ram_sel = 1; rbt_ram_addr = 16'd4;
    tick;
    chk("ld_rd_dram4", rbt_ram_dat_rd, 32'h0000_1234);

    // Clear and write in the same cycle: clear wins, write still lands
    rbt_ram_sel = 0; rbt_ram_addr = 16'd1; rbt_ram_dat_wr = 32'hFFFF_FFFF;
    rbt_ram_wr = 1; crc_clr = 1;
    tick;
    rbt_ram_wr = 0; crc_clr = 0;
    chk("clr_wins_crc", crc32, 32'd0);
    chk("clr_wins_mem", iram_mem[1], 32'hFFFF_FFFF);
    rbt_ram_addr = 16'd2; rbt_ram_dat_wr = 32'd0; rbt_ram_wr = 1;
    tick;
    rbt_ram_wr = 0;
    chk("ld2_crc", crc32, 32'h2144_DF1C);

    // CPU is not served while the loader owns the RAMs
    cpu_stb = 1; cpu_we = 0; cpu_adr = 17'h0_0008;
    tick;
    chk("rbt_cpu_noack1", {31'b0, cpu_ack}, 32'd0);
    tick;
    chk("rbt_cpu_noack2", {31'b0, cpu_ack}, 32'd0);
    cpu_stb = 0;

    // Loader releases
    rbt_enable = 0;
    tick;
    chk("rel_grant", {31'b0, rbt_grant}, 32'd0);
    chk("rel_hold", {31'b0, cpu_hold}, 32'd0);

    // Loader write without grant is dropped
    rbt_ram_sel = 0; rbt_ram_addr = 16'd3; rbt_ram_dat_wr = 32'hCAFE_F00D; rbt_ram_wr = 1;
    #1;
    chk("drop_no_we", {30'b0, iram_we, dram_we}, 32'd0);
    tick;
    rbt_ram_wr = 0;
    chk("drop_flag", {31'b0, rbt_wr_drop}, 32'd1);
    chk("drop_mem", iram_mem[3], 32'h1111_1111);
    chk("drop_crc", crc32, 32'h2144_DF1C);
    tick;
    tick;
    chk("drop_sticky", {31'b0, rbt_wr_drop}, 32'd1);

    // Reset in the middle of an access
    cpu_stb = 1; cpu_we = 1; cpu_adr = 17'h0_0005; cpu_dat_wr = 32'h1234_5678;
    tick;
    chk("mid_acc_en", {31'b0, iram_en}, 32'd1);
    rst_n = 0;
    #1;
    chk("mid_rst_ack", {31'b0, cpu_ack}, 32'd0);
    chk("mid_rst_en", {30'b0, iram_en, dram_en}, 32'd0);
    chk("mid_rst_crc", crc32, 32'd0);
    chk("mid_rst_drop", {31'b0, rbt_wr_drop}, 32'd0);
    tick;
    chk("mid_rst_ack2", {31'b0, cpu_ack}, 32'd0);
    cpu_stb = 0;
    rst_n = 1;
    tick;
    chk("post_rst_ack", {31'b0, cpu_ack}, 32'd0);
    tick;
    chk("post_rst_ack2", {31'b0, cpu_ack}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
